// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core.
// The LAP state exists only when STOPWATCH_LAP_EN is defined.
package stopwatch_pkg;

  localparam int unsigned DigitW = 4;

  localparam int unsigned CsUMod  = 10;
  localparam int unsigned CsTMod  = 10;
  localparam int unsigned SecUMod = 10;
  localparam int unsigned SecTMod = 6;
  localparam int unsigned MinUMod = 10;
  localparam int unsigned MinTMod = 10;

  // Each cs_f transition represents this many milliseconds.
  localparam int unsigned TickMs = 10;

`ifdef STOPWATCH_LAP_EN
  typedef enum logic [1:0] {StIdle, StRun, StPause, StLap} sw_state_e;
`else
  typedef enum logic [1:0] {StIdle, StRun, StPause} sw_state_e;
`endif

  typedef struct packed {
    logic [DigitW-1:0] min_t;
    logic [DigitW-1:0] min_u;
    logic [DigitW-1:0] sec_t;
    logic [DigitW-1:0] sec_u;
    logic [DigitW-1:0] cs_t;
    logic [DigitW-1:0] cs_u;
  } bcd_time_t;

  localparam bcd_time_t ZeroTime = '0;

  function automatic bcd_time_t max_time(input int unsigned max_min);
    bcd_time_t t;
    t.min_t = DigitW'(max_min / 10);
    t.min_u = DigitW'(max_min % 10);
    t.sec_t = DigitW'(SecTMod - 1);
    t.sec_u = DigitW'(SecUMod - 1);
    t.cs_t  = DigitW'(CsTMod - 1);
    t.cs_u  = DigitW'(CsUMod - 1);
    return t;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit: counts 0..Modulus-1 on en, carry is combinational so
// carries ripple through a digit chain within one cycle.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned Modulus = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [DigitW-1:0] q,
  output logic              carry
);

  localparam logic [DigitW-1:0] Last = DigitW'(Modulus - 1);

  logic [DigitW-1:0] cnt_q, cnt_d;

  assign carry = en && (cnt_q == Last);
  assign q     = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = carry ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch: MM:SS.cc BCD count driven by a 10 ms toggle, start/stop and lap buttons.
// Optional lap capture/display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MIN  = 59,
  parameter bit          DBG_HOLD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_f,
  input  logic              start_stop,
  input  logic              lap_btn,
  output logic [DigitW-1:0] min_t,
  output logic [DigitW-1:0] min_u,
  output logic [DigitW-1:0] sec_t,
  output logic [DigitW-1:0] sec_u,
  output logic [DigitW-1:0] cs_t,
  output logic [DigitW-1:0] cs_u,
  output logic              running,
  output logic              ovf
);

  localparam bcd_time_t MaxTime = max_time(MAX_MIN);

  logic cs_f_q, start_stop_q, lap_btn_q;
  logic tick, ss_cmd, lap_cmd;

  sw_state_e state_q, state_d;
  logic      clr_live;
  logic      count_en, hold, wrap, cnt_clr;
  logic      ovf_q;

  bcd_time_t live, shown, disp_q;
  logic      c_cs_u, c_cs_t, c_sec_u, c_sec_t, c_min_u, c_min_t;

  // Sample registers always track inputs, so release from reset never sees an edge.
  always_ff @(posedge clk) begin
    cs_f_q       <= cs_f;
    start_stop_q <= start_stop;
    lap_btn_q    <= lap_btn;
  end

  assign tick    = cs_f ^ cs_f_q;
  assign ss_cmd  = start_stop & ~start_stop_q;
  assign lap_cmd = lap_btn & ~lap_btn_q;

`ifdef STOPWATCH_LAP_EN
  logic      lap_load;
  bcd_time_t lap_q;
  assign running = (state_q == StRun) || (state_q == StLap);
`else
  assign running = (state_q == StRun);
`endif

  assign hold     = DBG_HOLD && (state_q == StRun) && lap_btn;
  assign count_en = tick && running && !hold;

  always_comb begin
    state_d  = state_q;
    clr_live = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap_load = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (ss_cmd) state_d = StRun;
      end
      StRun: begin
        if (ss_cmd) begin
          state_d = StPause;
`ifdef STOPWATCH_LAP_EN
        end else if (lap_cmd) begin
          state_d  = StLap;
          lap_load = 1'b1;
`endif
        end
      end
`ifdef STOPWATCH_LAP_EN
      StLap: begin
        if (ss_cmd) begin
          state_d = StPause;
        end else if (lap_cmd) begin
          state_d = StRun;
        end
      end
`endif
      StPause: begin
        if (ss_cmd) begin
          state_d = StRun;
        end else if (lap_cmd) begin
          state_d  = StIdle;
          clr_live = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // A tens-of-minutes rollover is also a wrap, covering MAX_MIN = 99.
  assign wrap    = (count_en && (live == MaxTime)) || c_min_t;
  assign cnt_clr = clr_live || wrap;

  bcd_digit_counter #(.Modulus(CsUMod)) u_cs_u (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (count_en),
    .q     (live.cs_u),
    .carry (c_cs_u)
  );

  bcd_digit_counter #(.Modulus(CsTMod)) u_cs_t (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (c_cs_u),
    .q     (live.cs_t),
    .carry (c_cs_t)
  );

  bcd_digit_counter #(.Modulus(SecUMod)) u_sec_u (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (c_cs_t),
    .q     (live.sec_u),
    .carry (c_sec_u)
  );

  bcd_digit_counter #(.Modulus(SecTMod)) u_sec_t (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (c_sec_u),
    .q     (live.sec_t),
    .carry (c_sec_t)
  );

  bcd_digit_counter #(.Modulus(MinUMod)) u_min_u (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (c_sec_t),
    .q     (live.min_u),
    .carry (c_min_u)
  );

  bcd_digit_counter #(.Modulus(MinTMod)) u_min_t (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (c_min_u),
    .q     (live.min_t),
    .carry (c_min_t)
  );

  always_ff @(posedge clk) begin
    if (rst || clr_live) begin
      ovf_q <= 1'b0;
    end else if (wrap) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;

`ifdef STOPWATCH_LAP_EN
  // Captures the pre-increment count on the same edge as the lap command.
  always_ff @(posedge clk) begin
    if (rst || clr_live) begin
      lap_q <= ZeroTime;
    end else if (lap_load) begin
      lap_q <= live;
    end
  end
`endif

  always_comb begin
    shown = live;
`ifdef STOPWATCH_LAP_EN
    if (state_q == StLap) shown = lap_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= ZeroTime;
    end else begin
      disp_q <= shown;
    end
  end

  assign min_t = disp_q.min_t;
  assign min_u = disp_q.min_u;
  assign sec_t = disp_q.sec_t;
  assign sec_u = disp_q.sec_u;
  assign cs_t  = disp_q.cs_t;
  assign cs_u  = disp_q.cs_u;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core (MAX_MIN = 1); lap checks follow STOPWATCH_LAP_EN.
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_f = 1'b0;
  logic       start_stop = 1'b0;
  logic       lap_btn = 1'b0;
  logic [3:0] min_t, min_u, sec_t, sec_u, cs_t, cs_u;
  logic       running, ovf;

  int n_vec  = 0;
  int n_miss = 0;

  stopwatch_core #(
    .MAX_MIN  (1),
    .DBG_HOLD (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cs_f       (cs_f),
    .start_stop (start_stop),
    .lap_btn    (lap_btn),
    .min_t      (min_t),
    .min_u      (min_u),
    .sec_t      (sec_t),
    .sec_u      (sec_u),
    .cs_t       (cs_t),
    .cs_u       (cs_u),
    .running    (running),
    .ovf        (ovf)
  );

  always #10 clk = ~clk;

  function automatic logic [23:0] disp();
    return {min_t, min_u, sec_t, sec_u, cs_t, cs_u};
  endfunction

  task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic toggle_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cs_f = ~cs_f;
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle press of the chosen buttons, optionally with a cs_f toggle on the same edge.
  task automatic press(input bit ss, input bit lp, input bit tk);
    @(negedge clk);
    start_stop = ss;
    lap_btn    = lp;
    if (tk) cs_f = ~cs_f;
    @(negedge clk);
    start_stop = 1'b0;
    lap_btn    = 1'b0;
  endtask

  initial begin
    wait_n(2);
    rst = 1'b0;
    wait_n(1);
    check_eq("reset_disp", disp(), 24'h000000);
    check_eq("reset_running", {23'd0, running}, 24'd0);
    check_eq("reset_ovf", {23'd0, ovf}, 24'd0);

    toggle_n(5);
    wait_n(2);
    check_eq("idle_no_count", disp(), 24'h000000);

    press(1'b1, 1'b0, 1'b0);
    check_eq("start_running", {23'd0, running}, 24'd1);
    toggle_n(150);
    wait_n(1);
    check_eq("disp_lag", disp(), 24'h000149);
    wait_n(1);
    check_eq("count_150", disp(), 24'h000150);

    toggle_n(5849);
    wait_n(2);
    check_eq("preload_59_99", disp(), 24'h005999);
    toggle_n(1);
    wait_n(1);
    check_eq("carry_hold", disp(), 24'h005999);
    wait_n(1);
    check_eq("carry_minute", disp(), 24'h010000);

    toggle_n(5999);
    wait_n(2);
    check_eq("max_time", disp(), 24'h015999);
    check_eq("ovf_before_wrap", {23'd0, ovf}, 24'd0);
    toggle_n(1);
    wait_n(1);
    check_eq("wrap_ovf", {23'd0, ovf}, 24'd1);
    wait_n(1);
    check_eq("wrap_disp", disp(), 24'h000000);

    toggle_n(10);
    wait_n(2);
    check_eq("ovf_sticky", {23'd0, ovf}, 24'd1);
    check_eq("count_after_wrap", disp(), 24'h000010);

    // Tick on the RUN->PAUSE edge counts; ticks in PAUSE and on PAUSE->RUN do not.
    press(1'b1, 1'b0, 1'b1);
    check_eq("pause_running", {23'd0, running}, 24'd0);
    toggle_n(3);
    wait_n(2);
    check_eq("pause_tick_counted", disp(), 24'h000011);
    press(1'b1, 1'b0, 1'b1);
    wait_n(2);
    check_eq("resume_tick_dropped", disp(), 24'h000011);
    check_eq("resume_running", {23'd0, running}, 24'd1);

    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    wait_n(1);
    check_eq("clear_disp", disp(), 24'h000000);
    check_eq("clear_ovf", {23'd0, ovf}, 24'd0);
    check_eq("clear_idle", {23'd0, running}, 24'd0);
    press(1'b0, 1'b1, 1'b0);
    check_eq("idle_lap_ignored", {23'd0, running}, 24'd0);

    press(1'b1, 1'b0, 1'b0);
    toggle_n(200);
    wait_n(2);
    check_eq("count_200", disp(), 24'h000200);
    press(1'b0, 1'b1, 1'b0);
    toggle_n(300);
    wait_n(2);
`ifdef STOPWATCH_LAP_EN
    check_eq("lap_hold", disp(), 24'h000200);
    check_eq("lap_running", {23'd0, running}, 24'd1);
    press(1'b0, 1'b1, 1'b0);
    wait_n(1);
`endif
    check_eq("live_500", disp(), 24'h000500);

    press(1'b1, 1'b1, 1'b0);
    wait_n(1);
    check_eq("both_pause", {23'd0, running}, 24'd0);
    check_eq("both_live", disp(), 24'h000500);

    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    toggle_n(7);
    @(negedge clk);
    rst  = 1'b1;
    cs_f = ~cs_f;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_disp", disp(), 24'h000000);
    check_eq("rst_running", {23'd0, running}, 24'd0);
    check_eq("rst_ovf", {23'd0, ovf}, 24'd0);
    toggle_n(5);
    wait_n(2);
    check_eq("rst_idle", disp(), 24'h000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
